logic_result_stage: RTL and testbench
=====================================

LOGIC_RESULT_STAGE -- requirements
Module: logic_result_stage

Interface
REQ-001 Port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-002 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 Port in_valid, input, 1 bit: upstream logic-unit result present.
REQ-004 Port in_ready, output, 1 bit: stage can accept; a transfer occurs on a clk edge when in_valid and in_ready are both 1.
REQ-005 Port in_data, input, 16 bits: logic-unit result word (logic_out of the upstream stage).
REQ-006 Port in_sel, input, 4 bits: 4-bit op select that produced in_data.
REQ-007 Port out_valid, output, 1 bit: registered result available downstream.
REQ-008 Port out_ready, input, 1 bit: downstream accepts; a pop occurs when out_valid and out_ready are both 1.
REQ-009 Port out_data, output, 16 bits: head result word.
REQ-010 Port out_sel, output, 4 bits: op select travelling with out_data.
REQ-011 Port out_zero, output, 1 bit: head word equals 16'h0000.
REQ-012 Port out_ones, output, 1 bit: head word equals 16'hFFFF.
REQ-013 Port out_parity, output, 1 bit: XOR-reduction of head word.

Function
REQ-014 Stage SHALL be a 2-entry skid buffer (head register plus skid register) with states EMPTY, ONE, FULL.
REQ-015 in_ready SHALL be 1 in EMPTY and ONE and 0 in FULL, decoded from the state register only, with no combinational path from out_ready.
REQ-016 out_valid SHALL be 1 in ONE and FULL and 0 in EMPTY.
REQ-017 Flags SHALL be computed from in_data at capture and stored with the entry, never recomputed from out_data.
REQ-018 Latency: a word accepted at edge N SHALL appear on out_data with out_valid=1 after edge N when the buffer was EMPTY.
REQ-019 EMPTY with accept SHALL load the head and go to ONE.
REQ-020 ONE with accept and no pop SHALL load the skid and go to FULL.
REQ-021 ONE with simultaneous accept and pop SHALL load the head with the new word and stay in ONE.
REQ-022 ONE with pop and no accept SHALL go to EMPTY.
REQ-023 FULL with pop SHALL copy the skid into the head and go to ONE; accept is impossible in FULL.
REQ-024 Order SHALL be strict FIFO; no word dropped or duplicated under any in_valid/out_ready pattern.
REQ-025 out_data, out_sel and flags SHALL hold stable while out_valid=1 and out_ready=0.

Reset
REQ-026 rst=1 SHALL force EMPTY immediately, independent of clk.
REQ-027 During reset: out_valid=0, out_data=0, out_sel=0, out_zero=0, out_ones=0, out_parity=0, and in_ready=1 from the first edge after deassertion.
REQ-028 Reset mid-transfer SHALL discard both entries; no partial word is emitted after release.

Configuration
REQ-029 Macro LOGIC_RESULT_STATS_EN defined SHALL add output stat_count (16 bits), which counts pops, saturates at 16'hFFFF and resets to 0.
REQ-030 Macro LOGIC_RESULT_STATS_EN defined SHALL also add output stat_zero (16 bits), which counts pops with out_zero=1, saturates at 16'hFFFF and resets to 0.
REQ-031 Macro undefined SHALL remove both ports and counters, with identical datapath behaviour.

Structure
REQ-032 Shared package logic_pkg SHALL hold DATA_W=16, SEL_W=4 and the state encoding EMPTY=2'd0, ONE=2'd1, FULL=2'd2.
REQ-033 A combinational sub-module logic_flags SHALL compute zero, ones and parity from a 16-bit word, instantiated once on the capture path.

Verification
REQ-034 Bench SHALL cover: reset, in_valid=1, in_data=16'h0000, in_sel=4'b0011, out_ready=1 -> next cycle out_data=0000, out_zero=1, out_parity=0, out_sel=0011.
REQ-035 Bench SHALL cover: out_ready=0, push 16'h00FF then 16'hFFFF -> state FULL, in_ready=0, out_data=00FF, out_parity=0; raise out_ready -> 00FF then FFFF with out_ones=1.
REQ-036 Bench SHALL cover: continuous in_valid=1 and out_ready=1 streaming 16'h0001..16'h0010 -> one word per cycle, in order, out_parity alternating per popcount.
REQ-037 Bench SHALL cover: FULL holding 1234 and ABCD, assert rst asynchronously mid-cycle -> out_valid=0 before next edge, and neither word appears after release.
REQ-038 Bench SHALL cover: with LOGIC_RESULT_STATS_EN defined, 70000 pops including 3 zero words -> stat_count=FFFF, stat_zero=3.
REQ-039 Bench SHALL cover: random in_valid/out_ready at 50% each for 10000 cycles -> scoreboard shows FIFO order and flags matching recomputation.

Source files
------------

// File: rtl/logic_pkg.sv
// -----------------------------------------------------------------------------
// logic_pkg
// Shared widths, state encoding and stored-entry layout for the logic-unit
// result stage. Imported by logic_flags and logic_result_stage.
// -----------------------------------------------------------------------------
package logic_pkg;

    localparam int DATA_W = 16;
    localparam int SEL_W  = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    // One buffered result: word, its op select and the flags captured with it.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [SEL_W-1:0]  sel;
        logic              zero;
        logic              ones;
        logic              parity;
    } entry_t;

endpackage

// File: rtl/logic_flags.sv
// -----------------------------------------------------------------------------
// logic_flags
// Combinational word classifier.
//   word   : input  [DATA_W-1:0] result word
//   zero   : output, word is all zeros
//   ones   : output, word is all ones
//   parity : output, XOR-reduction of word
// -----------------------------------------------------------------------------
module logic_flags
    import logic_pkg::*;
(
    input  logic [DATA_W-1:0] word,
    output logic              zero,
    output logic              ones,
    output logic              parity
);

    assign zero   = (word == '0);
    assign ones   = (word == '1);
    assign parity = ^word;

endmodule

// File: rtl/logic_result_stage.sv
// -----------------------------------------------------------------------------
// logic_result_stage
// Two-entry skid buffer (head + skid register) that registers logic-unit
// results together with zero/ones/parity flags computed at capture time.
//
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   in_valid/in_ready        : upstream handshake (in_ready depends on state only)
//   in_data, in_sel          : result word and the op select that produced it
//   out_valid/out_ready      : downstream handshake
//   out_data, out_sel        : head entry word and op select
//   out_zero/ones/parity     : flags stored with the head entry
//   stat_count, stat_zero    : saturating pop / zero-word-pop counters, present
//                              only when LOGIC_RESULT_STATS_EN is defined
// -----------------------------------------------------------------------------
module logic_result_stage
    import logic_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]  in_sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [SEL_W-1:0]  out_sel,
    output logic              out_zero,
    output logic              out_ones,
    output logic              out_parity
`ifdef LOGIC_RESULT_STATS_EN
    ,
    output logic [15:0]       stat_count,
    output logic [15:0]       stat_zero
`endif
);

    state_t state_p0, state_nxt;
    entry_t head_p0, skid_p1, in_entry;
    logic   accept, pop;
    logic   head_load_in, head_load_skid, skid_load;
    logic   f_zero, f_ones, f_parity;

    // Capture path: flags are derived from the incoming word exactly once.
    logic_flags u_flags (
        .word   (in_data),
        .zero   (f_zero),
        .ones   (f_ones),
        .parity (f_parity)
    );

    assign in_entry = '{data: in_data, sel: in_sel, zero: f_zero, ones: f_ones, parity: f_parity};

    assign in_ready  = (state_p0 != FULL);
    assign out_valid = (state_p0 == ONE) || (state_p0 == FULL);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_nxt      = state_p0;
        head_load_in   = 1'b0;
        head_load_skid = 1'b0;
        skid_load      = 1'b0;
        unique case (state_p0)
            EMPTY: begin
                if (accept) begin
                    head_load_in = 1'b1;
                    state_nxt    = ONE;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    head_load_in = 1'b1;
                end else if (accept) begin
                    skid_load = 1'b1;
                    state_nxt = FULL;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only a pop can move the buffer.
                if (pop) begin
                    head_load_skid = 1'b1;
                    state_nxt      = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_p0 <= EMPTY;
        end else begin
            state_p0 <= state_nxt;
        end
    end

    // Stage 0: head register driving the outputs. Cleared on reset so the
    // outputs read zero while reset is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_p0 <= '0;
        end else if (head_load_in) begin
            head_p0 <= in_entry;
        end else if (head_load_skid) begin
            head_p0 <= skid_p1;
        end
    end

    // Stage 1: skid register, filled only when the head is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_p1 <= '0;
        end else if (skid_load) begin
            skid_p1 <= in_entry;
        end
    end

    assign out_data   = head_p0.data;
    assign out_sel    = head_p0.sel;
    assign out_zero   = head_p0.zero;
    assign out_ones   = head_p0.ones;
    assign out_parity = head_p0.parity;

`ifdef LOGIC_RESULT_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_count <= '0;
            stat_zero  <= '0;
        end else if (pop) begin
            stat_count <= sat_inc(stat_count);
            if (head_p0.zero) begin
                stat_zero <= sat_inc(stat_zero);
            end
        end
    end
`endif

endmodule

// File: tb/tb_logic_result_stage.sv
// -----------------------------------------------------------------------------
// tb_logic_result_stage
// Self-checking bench for logic_result_stage: directed vector table, hand
// sequences for streaming and asynchronous reset, randomized traffic against a
// queue-based reference model, and (with LOGIC_RESULT_STATS_EN) the counters.
// -----------------------------------------------------------------------------
module tb_logic_result_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_sel;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  out_sel;
    logic        out_zero;
    logic        out_ones;
    logic        out_parity;
`ifdef LOGIC_RESULT_STATS_EN
    logic [15:0] stat_count;
    logic [15:0] stat_zero;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    logic_result_stage dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sel    (out_sel),
        .out_zero   (out_zero),
        .out_ones   (out_ones),
        .out_parity (out_parity)
`ifdef LOGIC_RESULT_STATS_EN
        ,
        .stat_count (stat_count),
        .stat_zero  (stat_zero)
`endif
    );

    typedef struct {
        logic        iv;
        logic [15:0] d;
        logic [3:0]  s;
        logic        ordy;
        logic        e_ov;
        logic [15:0] e_d;
        logic [3:0]  e_s;
        logic        e_z;
        logic        e_o;
        logic        e_p;
        logic        e_ir;
    } vec_t;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  s;
    } word_t;

    vec_t  tbl[10];
    word_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Compare the DUT head against the reference queue; flags recomputed here.
    task automatic chk_model(input string tag);
        chk({tag, " in_ready"},  in_ready,  q.size() < 2);
        chk({tag, " out_valid"}, out_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk({tag, " out_data"},   out_data,   q[0].d);
            chk({tag, " out_sel"},    out_sel,    q[0].s);
            chk({tag, " out_zero"},   out_zero,   q[0].d == 16'h0000);
            chk({tag, " out_ones"},   out_ones,   q[0].d == 16'hFFFF);
            chk({tag, " out_parity"}, out_parity, $countones(q[0].d) % 2);
        end
    endtask

    initial begin
        logic acc, pp;
        word_t w;

        tbl[0] = '{1'b1, 16'h0000, 4'b0011, 1'b1, 1'b1, 16'h0000, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 16'h0000, 4'b0000, 1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 16'h00FF, 4'b0001, 1'b0, 1'b1, 16'h00FF, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 16'hFFFF, 4'b0010, 1'b0, 1'b1, 16'h00FF, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 16'h5555, 4'b1111, 1'b0, 1'b1, 16'h00FF, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 16'h0000, 4'b0000, 1'b1, 1'b1, 16'hFFFF, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 16'h0000, 4'b0000, 1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 16'h0007, 4'b0101, 1'b1, 1'b1, 16'h0007, 4'b0101, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[8] = '{1'b1, 16'h0003, 4'b0110, 1'b1, 1'b1, 16'h0003, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[9] = '{1'b0, 16'h0000, 4'b0000, 1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset values while rst is held.
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst out_valid",  out_valid,  1'b0);
        chk("rst out_data",   out_data,   16'h0000);
        chk("rst out_sel",    out_sel,    4'h0);
        chk("rst out_zero",   out_zero,   1'b0);
        chk("rst out_ones",   out_ones,   1'b0);
        chk("rst out_parity", out_parity, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("post-rst in_ready", in_ready, 1'b1);

        // Directed table: zero word, fill to FULL, blocked accept, drain,
        // empty-accept and simultaneous accept/pop.
        for (int i = 0; i < 10; i++) begin
            in_valid  = tbl[i].iv;
            in_data   = tbl[i].d;
            in_sel    = tbl[i].s;
            out_ready = tbl[i].ordy;
            step();
            chk($sformatf("tbl%0d out_valid", i), out_valid, tbl[i].e_ov);
            chk($sformatf("tbl%0d in_ready", i),  in_ready,  tbl[i].e_ir);
            if (tbl[i].e_ov) begin
                chk($sformatf("tbl%0d out_data", i),   out_data,   tbl[i].e_d);
                chk($sformatf("tbl%0d out_sel", i),    out_sel,    tbl[i].e_s);
                chk($sformatf("tbl%0d out_zero", i),   out_zero,   tbl[i].e_z);
                chk($sformatf("tbl%0d out_ones", i),   out_ones,   tbl[i].e_o);
                chk($sformatf("tbl%0d out_parity", i), out_parity, tbl[i].e_p);
            end
        end

        // Back-to-back streaming 0x0001..0x0010, one word per cycle.
        for (int i = 1; i <= 16; i++) begin
            in_valid  = 1'b1;
            in_data   = 16'(i);
            in_sel    = 4'(i);
            out_ready = 1'b1;
            step();
            chk("stream out_valid",  out_valid,  1'b1);
            chk("stream in_ready",   in_ready,   1'b1);
            chk("stream out_data",   out_data,   16'(i));
            chk("stream out_parity", out_parity, $countones(i) % 2);
        end
        in_valid = 1'b0;
        step();
        chk("stream drained", out_valid, 1'b0);

        // FULL with 1234/ABCD, then asynchronous reset mid-cycle.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h1234;
        in_sel    = 4'h1;
        step();
        in_data = 16'hABCD;
        in_sel  = 4'h2;
        step();
        in_valid = 1'b0;
        chk("full in_ready", in_ready, 1'b0);
        chk("full out_data", out_data, 16'h1234);
        #3;
        rst = 1'b1;
        #1;
        chk("async rst out_valid", out_valid, 1'b0);
        chk("async rst out_data",  out_data,  16'h0000);
        chk("async rst in_ready",  in_ready,  1'b1);
        @(negedge clk);
        #2;
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("after rst no word", out_valid, 1'b0);
        end

        // Randomized traffic against the queue model.
        do_reset();
        q.delete();
        for (int c = 0; c < 10000; c++) begin
            in_valid  = 1'($urandom % 2);
            in_data   = 16'($urandom);
            if ($urandom % 8 == 0) in_data = 16'h0000;
            if ($urandom % 8 == 0) in_data = 16'hFFFF;
            in_sel    = 4'($urandom);
            out_ready = 1'($urandom % 2);
            #3;
            chk_model("rand");
            acc = in_valid && (q.size() < 2);
            pp  = out_ready && (q.size() > 0);
            w.d = in_data;
            w.s = in_sel;
            @(posedge clk);
            if (pp) void'(q.pop_front());
            if (acc) q.push_back(w);
            #1;
        end
        in_valid = 1'b0;

`ifdef LOGIC_RESULT_STATS_EN
        // 70000 pops, three of them zero words.
        do_reset();
        chk("stat_count reset", stat_count, 16'h0000);
        chk("stat_zero reset",  stat_zero,  16'h0000);
        out_ready = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            in_valid = 1'b1;
            in_data  = (i == 5 || i == 33333 || i == 69990) ? 16'h0000 : (16'(i) | 16'h8000);
            in_sel   = 4'(i);
            step();
        end
        in_valid = 1'b0;
        repeat (3) step();
        chk("stat_count sat", stat_count, 16'hFFFF);
        chk("stat_zero",      stat_zero,  16'h0003);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
